stepper_pos_ctrl: RTL and testbench

//   Closed-count stepper driver for the balance platform: homes the carriage against end_left, then moves
//   it to a commanded absolute position by emitting step/dir pulses while tracking the position.

---
 rtl/stepper_pos_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_stepper_pos_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_pos_ctrl.sv
// stepper_pos_ctrl: homes a stepper carriage against end_left, then steps it to a
//   commanded absolute position while tracking the position.
// Latency: target_valid is latched on the next clock; the first step edge follows
//   after 0 or DIR_SETUP cycles (the wait is skipped when the direction is unchanged).
// Backpressure: none; trava holds motion at the next step boundary and a new target
//   takes effect at the next step boundary.
//
// Optional feature macro: ACCEL_EN (trapezoidal half-period ramp on moves).
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   calib                 1-cycle pulse, start homing from any state
//   target_pos/_valid     absolute target (clamped to POS_MAX) and its strobe
//   trava                 hold: no new step pulse starts while high
//   end_left/end_right    limit switches, active-high, already synchronised
//   step, dir             motor driver pins (dir=1 moves right, position increments)
//   busy, calib_done      activity / homed status
//   fault                 limit-switch or homing-timeout fault
//   current_pos           tracked position
//   db_estado             FSM state code for the debug display
module stepper_pos_ctrl #(
  parameter int STEP_HALF  = 25000,
  parameter int DIR_SETUP  = 50,
  parameter int POS_MAX    = 2000,
  parameter int BACKOFF    = 20,
  parameter int START_HALF = 100000,
  parameter int RAMP_DEC   = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        calib,
  input  logic [15:0] target_pos,
  input  logic        target_valid,
  input  logic        trava,
  input  logic        end_left,
  input  logic        end_right,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        calib_done,
  output logic        fault,
  output logic [15:0] current_pos,
  output logic [3:0]  db_estado
);

  // The cycle counter is shared by the half-period, direction-setup and ramp
  // arithmetic, so it is sized for the largest of those quantities.
  localparam int MAX_AB     = (STEP_HALF > START_HALF) ? STEP_HALF : START_HALF;
  localparam int MAX_CD     = (DIR_SETUP > RAMP_DEC) ? DIR_SETUP : RAMP_DEC;
  localparam int CNT_MAX    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int SEEK_LIMIT = POS_MAX + BACKOFF + 16;
  localparam int NW         = $clog2(SEEK_LIMIT + 1);

  localparam logic [CW-1:0] SETUP_LOAD = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(STEP_HALF - 1);
  localparam logic [NW-1:0] SEEK_N     = NW'(SEEK_LIMIT);
  localparam logic [NW-1:0] BACKOFF_N  = NW'(BACKOFF);
  localparam logic [15:0]   POS_TOP    = 16'(POS_MAX);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SEEK    = 4'd1,
    S_BACKOFF = 4'd2,
    S_READY   = 4'd3,
    S_SETUP   = 4'd4,
    S_STEP_HI = 4'd5,
    S_STEP_LO = 4'd6,
    S_FAULT   = 4'd7
  } state_t;

  // Homing keeps SEEK/BACKOFF visible on db_estado for its whole duration, so
  // the pulse timing inside those states runs on a private sub-phase.
  typedef enum logic [1:0] {
    PH_WAIT = 2'd0,
    PH_HI   = 2'd1,
    PH_LO   = 2'd2
  } phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] half_load;
  logic [NW-1:0] nstep;
  logic [15:0]   tgt;
  logic          want_up;
  logic          at_tgt;

  assign db_estado = state;
  assign want_up   = (tgt > current_pos);
  assign at_tgt    = (tgt == current_pos);

  function automatic logic [15:0] clamp_pos(input logic [15:0] v);
    return (v > POS_TOP) ? POS_TOP : v;
  endfunction

  // busy is registered together with the state it decodes.
  task automatic go(input state_t s);
    state <= s;
    busy  <= (s == S_SEEK) || (s == S_BACKOFF) || (s == S_SETUP) ||
             (s == S_STEP_HI) || (s == S_STEP_LO);
  endtask

  // Position moves on the rising step edge, so current_pos always counts the
  // pulse that is in flight.
  task automatic start_step();
    go(S_STEP_HI);
    step        <= 1'b1;
    current_pos <= dir ? current_pos + 16'd1 : current_pos - 16'd1;
    cnt         <= HALF_LOAD;
  endtask

`ifdef ACCEL_EN
  localparam logic [CW-1:0] HALF_MIN = CW'(STEP_HALF);
  localparam logic [CW-1:0] HALF_MAX = CW'(START_HALF);
  localparam logic [CW-1:0] HALF_DEC = CW'(RAMP_DEC);

  logic [CW-1:0] half;
  logic [CW-1:0] half_next;
  logic [15:0]   ramp_cnt;
  logic [15:0]   ramp_next;
  logic [15:0]   remaining;

  // Steps still to go before the pulse about to start (inclusive).
  assign remaining = dir ? (tgt - current_pos) : (current_pos - tgt);
  assign half_load = half - CW'(1);

  // Decelerate once the steps left no longer exceed the steps spent
  // accelerating; otherwise keep shortening the half-period to the floor.
  always_comb begin
    half_next = half;
    ramp_next = ramp_cnt;
    if (remaining <= ramp_cnt) begin
      if (({1'b0, half} + {1'b0, HALF_DEC}) >= {1'b0, HALF_MAX}) begin
        half_next = HALF_MAX;
      end else begin
        half_next = half + HALF_DEC;
      end
      if (ramp_cnt != 16'd0) begin
        ramp_next = ramp_cnt - 16'd1;
      end
    end else if (half > HALF_MIN) begin
      if ((half - HALF_MIN) > HALF_DEC) begin
        half_next = half - HALF_DEC;
      end else begin
        half_next = HALF_MIN;
      end
      ramp_next = ramp_cnt + 16'd1;
    end
  end

  task automatic ramp_restart();
    half     <= HALF_MAX;
    ramp_cnt <= 16'd0;
    cnt      <= HALF_MAX - CW'(1);
  endtask

  task automatic ramp_advance();
    half     <= half_next;
    ramp_cnt <= ramp_next;
    cnt      <= half_next - CW'(1);
  endtask
`else
  assign half_load = HALF_LOAD;

  task automatic ramp_restart();
  endtask

  task automatic ramp_advance();
  endtask
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= PH_WAIT;
      busy        <= 1'b0;
      step        <= 1'b0;
      dir         <= 1'b0;
      calib_done  <= 1'b0;
      fault       <= 1'b0;
      current_pos <= 16'd0;
      tgt         <= 16'd0;
      cnt         <= '0;
      nstep       <= '0;
`ifdef ACCEL_EN
      half        <= HALF_MIN;
      ramp_cnt    <= 16'd0;
`endif
    end else begin
      if (target_valid && !(state inside {S_IDLE, S_SEEK, S_BACKOFF})) begin
        tgt <= clamp_pos(target_pos);
      end

      if (calib) begin
        go(S_SEEK);
        phase      <= PH_WAIT;
        step       <= 1'b0;
        dir        <= 1'b0;
        fault      <= 1'b0;
        calib_done <= 1'b0;
        cnt        <= SETUP_LOAD;
        nstep      <= '0;
      end else if (state != S_SEEK && (dir ? end_right : end_left)) begin
        go(S_FAULT);
        step       <= 1'b0;
        fault      <= 1'b1;
        calib_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_FAULT: begin
          end

          S_SEEK, S_BACKOFF: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (phase == PH_HI) begin
              step  <= 1'b0;
              phase <= PH_LO;
              cnt   <= HALF_LOAD;
            end else if (state == S_SEEK) begin
              // Step boundary while seeking: switch, timeout, or next pulse.
              if (end_left) begin
                go(S_BACKOFF);
                current_pos <= 16'd0;
                dir         <= 1'b1;
                phase       <= PH_WAIT;
                cnt         <= SETUP_LOAD;
                nstep       <= '0;
              end else if (nstep == SEEK_N) begin
                go(S_FAULT);
                fault <= 1'b1;
              end else begin
                step  <= 1'b1;
                phase <= PH_HI;
                cnt   <= HALF_LOAD;
                nstep <= nstep + NW'(1);
              end
            end else begin
              if (nstep == BACKOFF_N) begin
                // Park at the backoff point: the stale pre-homing target
                // must not drive the carriage back into the switch.
                go(S_READY);
                calib_done <= 1'b1;
                tgt        <= current_pos;
              end else begin
                step        <= 1'b1;
                phase       <= PH_HI;
                cnt         <= HALF_LOAD;
                nstep       <= nstep + NW'(1);
                current_pos <= current_pos + 16'd1;
              end
            end
          end

          S_READY: begin
            if (!at_tgt && !trava) begin
              if (want_up == dir) begin
                start_step();
                ramp_restart();
              end else begin
                go(S_SETUP);
                dir <= want_up;
                cnt <= SETUP_LOAD;
              end
            end
          end

          S_SETUP: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (trava || at_tgt || (want_up != dir)) begin
              // Conditions changed during the wait; READY re-decides.
              go(S_READY);
            end else begin
              start_step();
              ramp_restart();
            end
          end

          S_STEP_HI: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              go(S_STEP_LO);
              step <= 1'b0;
              cnt  <= half_load;
            end
          end

          S_STEP_LO: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (at_tgt || trava) begin
              go(S_READY);
            end else if (want_up != dir) begin
              go(S_SETUP);
              dir <= want_up;
              cnt <= SETUP_LOAD;
            end else begin
              start_step();
              ramp_advance();
            end
          end

          default: begin
            go(S_IDLE);
            step <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stepper_pos_ctrl.sv
// tb_stepper_pos_ctrl: scoreboard bench for stepper_pos_ctrl with short timing
//   parameters; each move pushes its expected outcome and is checked when busy falls.
module tb_stepper_pos_ctrl;

  localparam int STEP_HALF = 4;
  localparam int DIR_SETUP = 2;
  localparam int POS_MAX   = 100;
  localparam int BACKOFF   = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        calib;
  logic [15:0] target_pos;
  logic        target_valid;
  logic        trava;
  logic        end_left;
  logic        end_right;
  logic        step;
  logic        dir;
  logic        busy;
  logic        calib_done;
  logic        fault;
  logic [15:0] current_pos;
  logic [3:0]  db_estado;

  stepper_pos_ctrl #(
    .STEP_HALF(STEP_HALF),
    .DIR_SETUP(DIR_SETUP),
    .POS_MAX  (POS_MAX),
    .BACKOFF  (BACKOFF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .calib       (calib),
    .target_pos  (target_pos),
    .target_valid(target_valid),
    .trava       (trava),
    .end_left    (end_left),
    .end_right   (end_right),
    .step        (step),
    .dir         (dir),
    .busy        (busy),
    .calib_done  (calib_done),
    .fault       (fault),
    .current_pos (current_pos),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts rising edges, flags high runs that are not exactly
  // one half-period and low runs shorter than one half-period.
  int   rise_total  = 0;
  int   hi_bad      = 0;
  int   lo_bad      = 0;
  int   setup_total = 0;
  int   hi_run      = 0;
  int   lo_run      = 100;
  logic step_q      = 1'b0;

  always @(posedge clock) begin
    if (step === 1'b1) begin
      if (step_q !== 1'b1) begin
        rise_total++;
        if (lo_run < STEP_HALF) lo_bad++;
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (step_q === 1'b1) begin
        if (hi_run != STEP_HALF) hi_bad++;
        lo_run = 0;
      end
      lo_run++;
    end
    step_q = step;
    if (db_estado == 4'd4) setup_total++;
  end

  function automatic int probe(input int sel);
    case (sel)
      0:       return int'(busy);
      1:       return int'(calib_done);
      2:       return int'(fault);
      3:       return int'(db_estado);
      4:       return int'(current_pos);
      default: return int'(step);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int val, input int max_cyc);
    int hit;
    hit = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (probe(sel) == val) begin
        hit = 1;
        break;
      end
    end
    chk(tag, hit, 1);
  endtask

  task automatic send_target(input int v);
    target_pos   = 16'(v);
    target_valid = 1'b1;
    @(negedge clock);
    target_valid = 1'b0;
  endtask

  typedef struct {
    string tag;
    int    pos;
    int    pulses;
    int    dir;
    int    setups;
    int    rbase;
    int    sbase;
    int    hbase;
    int    lbase;
  } exp_t;

  exp_t sb[$];

  task automatic expect_move(input string tag, input int pos, input int pulses,
                             input int d, input int setups, input int rbase);
    exp_t e;
    e.tag    = tag;
    e.pos    = pos;
    e.pulses = pulses;
    e.dir    = d;
    e.setups = setups;
    e.rbase  = rbase;
    e.sbase  = setup_total;
    e.hbase  = hi_bad;
    e.lbase  = lo_bad;
    sb.push_back(e);
  endtask

  task automatic finish_move();
    exp_t e;
    e = sb.pop_front();
    wait_for({e.tag, "_busy_rise"}, 0, 1, 50);
    wait_for({e.tag, "_busy_fall"}, 0, 0, 3000);
    chk({e.tag, "_pos"}, int'(current_pos), e.pos);
    chk({e.tag, "_pulses"}, rise_total - e.rbase, e.pulses);
    chk({e.tag, "_dir"}, int'(dir), e.dir);
    if (e.setups >= 0) chk({e.tag, "_setup_cycles"}, setup_total - e.sbase, e.setups);
    chk({e.tag, "_hi_width_errs"}, hi_bad - e.hbase, 0);
    chk({e.tag, "_lo_width_errs"}, lo_bad - e.lbase, 0);
    chk({e.tag, "_state"}, int'(db_estado), 3);
  endtask

  task automatic home(input string tag, input int seek_n);
    int base;
    int hit;
    base = rise_total;
    calib = 1'b1;
    @(negedge clock);
    calib = 1'b0;
    chk({tag, "_seek_state"}, int'(db_estado), 1);
    chk({tag, "_fault_clr"}, int'(fault), 0);
    hit = 0;
    for (int i = 0; i < seek_n * 2 * STEP_HALF + 50; i++) begin
      if ((rise_total - base) == seek_n && step == 1'b0) begin
        hit = 1;
        break;
      end
      @(negedge clock);
    end
    chk({tag, "_seek_wait"}, hit, 1);
    end_left = 1'b1;
    wait_for({tag, "_backoff_state"}, 3, 2, 20);
    end_left = 1'b0;
    chk({tag, "_seek_pulses"}, rise_total - base, seek_n);
    base = rise_total;
    wait_for({tag, "_done"}, 1, 1, 200);
    chk({tag, "_backoff_pulses"}, rise_total - base, BACKOFF);
    chk({tag, "_pos"}, int'(current_pos), BACKOFF);
    chk({tag, "_ready"}, int'(db_estado), 3);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_dir"}, int'(dir), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int rb;
    reset        = 1'b1;
    calib        = 1'b0;
    target_pos   = 16'd0;
    target_valid = 1'b0;
    trava        = 1'b0;
    end_left     = 1'b0;
    end_right    = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_calib_done", int'(calib_done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_pos", int'(current_pos), 0);
    chk("rst_state", int'(db_estado), 0);

    reset = 1'b0;
    @(negedge clock);

    // IDLE ignores targets.
    send_target(42);
    repeat (10) @(negedge clock);
    chk("idle_state", int'(db_estado), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_pulses", rise_total, 0);

    home("home", 10);

    // Same direction as the backoff: no setup wait.
    rb = rise_total;
    expect_move("m10", 10, 7, 1, 0, rb);
    send_target(10);
    finish_move();

    // Clamped target.
    rb = rise_total;
    expect_move("m500", POS_MAX, 90, 1, 0, rb);
    send_target(500);
    finish_move();
    chk("m500_fault", int'(fault), 0);

    rb = rise_total;
    expect_move("m20", 20, 80, 0, DIR_SETUP, rb);
    send_target(20);
    finish_move();

    // Reversal mid-move.
    rb = rise_total;
    send_target(50);
    wait_for("rev_pos30", 4, 30, 300);
    chk("rev_midpulse", int'(step), 1);
    expect_move("rev5", 5, 35, 0, DIR_SETUP, rb);
    send_target(5);
    finish_move();

    // trava during a pulse.
    rb = rise_total;
    send_target(40);
    wait_for("trava_pos16", 4, 16, 300);
    chk("trava_midpulse", int'(step), 1);
    trava = 1'b1;
    expect_move("trava_stop", 16, 11, 1, -1, rb);
    finish_move();
    repeat (30) @(negedge clock);
    chk("trava_hold_pos", int'(current_pos), 16);
    chk("trava_hold_pulses", rise_total - rb, 11);
    rb = rise_total;
    expect_move("trava_resume", 40, 24, 1, 0, rb);
    trava = 1'b0;
    finish_move();

    // Right limit hit while moving right.
    rb = rise_total;
    expect_move("m10b", 10, 30, 0, DIR_SETUP, rb);
    send_target(10);
    finish_move();
    send_target(50);
    wait_for("lim_pos20", 4, 20, 300);
    end_right = 1'b1;
    @(negedge clock);
    chk("lim_fault", int'(fault), 1);
    chk("lim_step", int'(step), 0);
    chk("lim_calib_done", int'(calib_done), 0);
    chk("lim_busy", int'(busy), 0);
    chk("lim_state", int'(db_estado), 7);
    rb = rise_total;
    send_target(60);
    repeat (20) @(negedge clock);
    chk("lim_hold_pulses", rise_total - rb, 0);
    chk("lim_hold_state", int'(db_estado), 7);
    end_right = 1'b0;
    home("rehome", 5);

    // Homing timeout: switch never seen.
    rb = rise_total;
    calib = 1'b1;
    @(negedge clock);
    calib = 1'b0;
    wait_for("seek_timeout", 2, 1, 2000);
    chk("seek_timeout_pulses", rise_total - rb, POS_MAX + BACKOFF + 16);
    chk("seek_timeout_state", int'(db_estado), 7);
    chk("seek_timeout_calib_done", int'(calib_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
